// File: rtl/onehot_enc_pkg.sv
// onehot_enc_pkg: shared widths, FSM state and popcount helper for the 16->4 sequential encoder
package onehot_enc_pkg;
  localparam int IN_W = 16;
  localparam int OUT_W = $clog2(IN_W);
  typedef enum logic {IDLE, EMIT} enc_state_e;
  typedef logic [OUT_W-1:0] enc_idx_t;
  function automatic logic [OUT_W:0] popcount(input logic [IN_W-1:0] v);
    popcount = '0;
    for (int i = 0; i < IN_W; i++) popcount = popcount + (OUT_W+1)'(v[i]);
  endfunction
endpackage

// File: rtl/find_first_set.sv
// find_first_set: combinational priority scan returning the first set bit index, any-set and exactly-one-set flags
module find_first_set
  import onehot_enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [IN_W-1:0] vec,
  output enc_idx_t        idx,
  output logic            found,
  output logic            single
);
  // later loop iterations win, so the scan runs from the lowest-priority end toward the winner
  always_comb begin
    idx = '0;
    for (int i = 0; i < IN_W; i++)
      if (vec[MSB_FIRST ? i : IN_W-1-i]) idx = OUT_W'(MSB_FIRST ? i : IN_W-1-i);
  end
  assign found  = |vec;
  assign single = found && ((vec & (vec - 1'b1)) == '0);
endmodule

// File: rtl/onehot_encoder_16_4.sv
// onehot_encoder_16_4: latches a request vector and emits each set bit index one beat per handshake (ONEHOT_ENC_MSB_FIRST_EN selects MSB-first order)
module onehot_encoder_16_4
  import onehot_enc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [IN_W-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  output enc_idx_t        out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            out_zero,
  output logic [OUT_W:0]  count
);
`ifdef ONEHOT_ENC_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif
  enc_state_e      state_q, state_d;
  logic [IN_W-1:0] pending_q, pending_d;
  enc_idx_t        out_q, out_d, nxt_idx;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d, out_zero_q, out_zero_d;
  logic [OUT_W:0]  count_q, count_d;
  logic            accept, hs, nxt_found, nxt_single;
  assign in_ready  = (state_q == IDLE) && enable;
  assign accept    = in_valid && in_ready;
  assign hs        = out_valid_q && out_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_zero  = out_zero_q;
  assign count     = count_q;
  // the scanner looks at next-cycle pending so the beat outputs can be registered
  find_first_set #(.MSB_FIRST(MSB_FIRST)) u_ffs (
    .vec(pending_d), .idx(nxt_idx), .found(nxt_found), .single(nxt_single)
  );
  // next-state: load on accept, retire the presented bit on handshake, hold while stalled
  always_comb begin
    pending_d   = accept ? in : hs ? (pending_q & ~(IN_W'(1) << out_q)) : pending_q;
    state_d     = (state_q == IDLE) ? (accept ? EMIT : IDLE) : ((hs && out_last_q) ? IDLE : EMIT);
    out_valid_d = (state_d == EMIT);
    out_d       = out_valid_d ? nxt_idx : out_q;
    out_last_d  = out_valid_d && (nxt_single || !nxt_found);
    out_zero_d  = accept ? (in == '0) : (out_valid_d && out_zero_q);
    count_d     = accept ? popcount(in) : count_q;
  end
  // state and registered outputs, cleared asynchronously so in-flight beats are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_zero_q  <= out_zero_d;
      count_q     <= count_d;
    end
  end
endmodule

// File: tb/tb_onehot_encoder_16_4.sv
// tb_onehot_encoder_16_4: directed self-checking bench for the sequential 16->4 encoder
module tb_onehot_encoder_16_4;
  logic        clk = 1'b0;
  logic        rst_n, enable, in_valid, out_ready;
  logic [15:0] in_v;
  logic        in_ready, out_valid, out_last, out_zero;
  logic [3:0]  out;
  logic [4:0]  count;
  int          checks = 0;
  int          failures = 0;
`ifdef ONEHOT_ENC_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  onehot_encoder_16_4 dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(in_v), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_zero(out_zero), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [15:0] v);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", 32'(in_ready), 1);
    in_v = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic beat(input string tag, input int idx, input logic last, input logic zero);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_out"}, 32'(out), 32'(idx));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    chk({tag, "_zero"}, 32'(out_zero), 32'(zero));
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_v = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_zero", 32'(out_zero), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0008);
    chk("t1_count", 32'(count), 1);
    chk("t1_in_ready_busy", 32'(in_ready), 0);
    beat("t1", 3, 1'b1, 1'b0);
    chk("t1_drained", 32'(out_valid), 0);
    chk("t1_in_ready", 32'(in_ready), 1);
    send(16'h8012);
    chk("t2_count", 32'(count), 3);
    beat("t2b0", MSB ? 15 : 1, 1'b0, 1'b0);
    beat("t2b1", 4, 1'b0, 1'b0);
    beat("t2b2", MSB ? 1 : 15, 1'b1, 1'b0);
    chk("t2_drained", 32'(out_valid), 0);
    chk("t2_count_hold", 32'(count), 3);
    send(16'h0000);
    chk("t3_count", 32'(count), 0);
    beat("t3", 0, 1'b1, 1'b1);
    chk("t3_drained", 32'(out_valid), 0);
    send(16'hFFFF);
    chk("t4_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      out_ready = 1'b0;
      chk("t4_valid", 32'(out_valid), 1);
      chk("t4_out", 32'(out), MSB ? 32'(15 - i) : 32'(i));
      chk("t4_last", 32'(out_last), (i == 15) ? 1 : 0);
      @(negedge clk);
      chk("t4_stall_valid", 32'(out_valid), 1);
      chk("t4_stall_out", 32'(out), MSB ? 32'(15 - i) : 32'(i));
      out_ready = 1'b1;
      @(negedge clk);
    end
    chk("t4_drained", 32'(out_valid), 0);
    send(16'h00F0);
    beat("t5b0", MSB ? 7 : 4, 1'b0, 1'b0);
    beat("t5b1", MSB ? 6 : 5, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(out_valid), 0);
    chk("t5_async_count", 32'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0100);
    chk("t5_count", 32'(count), 1);
    beat("t5", 8, 1'b1, 1'b0);
    chk("t5_drained", 32'(out_valid), 0);
    enable = 1'b0;
    in_v = 16'h0004;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", 32'(in_ready), 0);
    repeat (3) @(negedge clk);
    chk("t6_no_beat", 32'(out_valid), 0);
    chk("t6_count_hold", 32'(count), 1);
    in_valid = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      send(16'(1) << k);
      chk("rt_count", 32'(count), 1);
      beat("rt", k, 1'b1, 1'b0);
    end
    chk("rt_drained", 32'(out_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
